// File: rtl/seq_mult_if.sv
// Operand/result bundle between control (master) and the sequential multiplier (slave).
interface seq_mult_if #(
    parameter int unsigned WIDTH = 16
);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   Mem_Dat_X;
    logic [WIDTH-1:0]   Mem_Dat_Y;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic               overflow;

    modport master (
        output start, signed_mode, Mem_Dat_X, Mem_Dat_Y,
        input  busy, done, product, overflow
    );

    modport slave (
        input  start, signed_mode, Mem_Dat_X, Mem_Dat_Y,
        output busy, done, product, overflow
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add multiplier: magnitudes are multiplied unsigned over up to WIDTH
// iterations, then the sign is applied and overflow is judged in one fixup cycle.
module seq_mult_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    seq_mult_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CntMax = CW'(WIDTH);
    localparam logic [CW-1:0] CntOne = CW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           state_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             mode_q;
    logic             busy_q;
    logic             done_q;
    logic [PW-1:0]    product_q;
    logic             overflow_q;

    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic [PW-1:0]    acc_add;
    logic [WIDTH-1:0] mplier_shift;
    logic [CW-1:0]    cnt_inc;
    logic             run_last;
    logic [PW-1:0]    fix_prod;
    logic             fix_ovf;

    // Operand magnitudes, one iteration of the datapath, and the signed fixup result.
    always_comb begin
        x_mag        = (bus.signed_mode && bus.Mem_Dat_X[WIDTH-1]) ? -bus.Mem_Dat_X : bus.Mem_Dat_X;
        y_mag        = (bus.signed_mode && bus.Mem_Dat_Y[WIDTH-1]) ? -bus.Mem_Dat_Y : bus.Mem_Dat_Y;
        acc_add      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shift = mplier_q >> 1;
        cnt_inc      = cnt_q + CntOne;
        run_last     = (cnt_inc == CntMax) || (EARLY_EXIT && (mplier_shift == '0));
        fix_prod     = neg_q ? -acc_q : acc_q;
        if (mode_q) begin
            // Representable in WIDTH signed bits only if the top WIDTH+1 bits are sign copies.
            fix_ovf = !((&fix_prod[PW-1:WIDTH-1]) || (~|fix_prod[PW-1:WIDTH-1]));
        end else begin
            fix_ovf = |fix_prod[PW-1:WIDTH];
        end
    end

    // Controller FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, x_mag};
                        mplier_q <= y_mag;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        neg_q    <= bus.signed_mode & (bus.Mem_Dat_X[WIDTH-1] ^ bus.Mem_Dat_Y[WIDTH-1]);
                        mode_q   <= bus.signed_mode;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    acc_q    <= acc_add;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_shift;
                    cnt_q    <= cnt_inc;
                    if (run_last) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    product_q  <= fix_prod;
                    overflow_q <= fix_ovf;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.product  = product_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: dut0 runs full-length, dut1 has early exit enabled.
module tb_seq_mult_ctrl;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    seq_mult_if #(.WIDTH(W)) bus0 ();
    seq_mult_if #(.WIDTH(W)) bus1 ();

    seq_mult_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    seq_mult_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Present operands before an edge; returns #1 after the sampling edge (edge 0) with start low.
    task automatic launch(input bit ee, input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        if (ee) begin
            bus1.start = 1'b1; bus1.signed_mode = sm; bus1.Mem_Dat_X = x; bus1.Mem_Dat_Y = y;
        end else begin
            bus0.start = 1'b1; bus0.signed_mode = sm; bus0.Mem_Dat_X = x; bus0.Mem_Dat_Y = y;
        end
        @(posedge clk);
        #1;
        if (ee) bus1.start = 1'b0;
        else    bus0.start = 1'b0;
    endtask

    // Edge index (from the sampling edge) at which done is seen, or -1 if never.
    task automatic wait_done(input bit ee, input int max_edges, output int edges);
        edges = -1;
        for (int k = 1; k <= max_edges; k++) begin
            @(posedge clk);
            #1;
            if ((ee ? bus1.done : bus0.done) === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus0.busy, bus0.done, bus0.overflow} !== 3'b000 || bus0.product !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_dut0: busy=%b done=%b ovf=%b product=%h, required all zero",
                     bus0.busy, bus0.done, bus0.overflow, bus0.product);
        end
        n_checks++;
        if ({bus1.busy, bus1.done, bus1.overflow} !== 3'b000 || bus1.product !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_dut1: busy=%b done=%b ovf=%b product=%h, required all zero",
                     bus1.busy, bus1.done, bus1.overflow, bus1.product);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_signed_basic();
        int busy_bad = 0;
        launch(1'b0, 1'b1, 16'd10, 16'hFFF1);
        if (bus0.busy !== 1'b1) busy_bad++;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k < 17) begin
                if (bus0.busy !== 1'b1 || bus0.done !== 1'b0) busy_bad++;
            end else begin
                n_checks++;
                if (bus0.busy !== 1'b0 || bus0.done !== 1'b1) begin
                    n_fails++;
                    $display("FAIL signed_done_edge17: busy=%b done=%b, required busy=0 done=1",
                             bus0.busy, bus0.done);
                end
            end
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fails++;
            $display("FAIL signed_busy_window: %0d bad cycles, required 0", busy_bad);
        end
        n_checks++;
        if (bus0.product !== 32'hFFFFFF6A || bus0.overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL signed_10x-15: product=%h ovf=%b, required FFFFFF6A ovf=0",
                     bus0.product, bus0.overflow);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus0.done !== 1'b0) begin
            n_fails++;
            $display("FAIL done_one_cycle: done=%b, required 0", bus0.done);
        end
    endtask

    task automatic test_unsigned_max();
        int e;
        launch(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        wait_done(1'b0, 25, e);
        n_checks++;
        if (e !== 17 || bus0.product !== 32'hFFFE0001 || bus0.overflow !== 1'b1) begin
            n_fails++;
            $display("FAIL unsigned_ffff_sq: edge=%0d product=%h ovf=%b, required 17 FFFE0001 1",
                     e, bus0.product, bus0.overflow);
        end
    endtask

    task automatic test_most_negative();
        int e;
        launch(1'b0, 1'b1, 16'h8000, 16'h8000);
        wait_done(1'b0, 25, e);
        n_checks++;
        if (e !== 17 || bus0.product !== 32'h40000000 || bus0.overflow !== 1'b1) begin
            n_fails++;
            $display("FAIL signed_min_sq: edge=%0d product=%h ovf=%b, required 17 40000000 1",
                     e, bus0.product, bus0.overflow);
        end
        launch(1'b0, 1'b1, 16'h8000, 16'h0001);
        wait_done(1'b0, 25, e);
        n_checks++;
        if (e !== 17 || bus0.product !== 32'hFFFF8000 || bus0.overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL signed_min_x1: edge=%0d product=%h ovf=%b, required 17 FFFF8000 0",
                     e, bus0.product, bus0.overflow);
        end
    endtask

    task automatic test_early_exit();
        int e;
        launch(1'b1, 1'b0, 16'd5, 16'd3);
        wait_done(1'b1, 25, e);
        n_checks++;
        if (e !== 3 || bus1.product !== 32'd15 || bus1.overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL ee_5x3: edge=%0d product=%h ovf=%b, required 3 0000000F 0",
                     e, bus1.product, bus1.overflow);
        end
        launch(1'b1, 1'b0, 16'd7, 16'd0);
        wait_done(1'b1, 25, e);
        n_checks++;
        if (e !== 2 || bus1.product !== 32'd0) begin
            n_fails++;
            $display("FAIL ee_7x0: edge=%0d product=%h, required 2 00000000", e, bus1.product);
        end
        // -2 * -3: multiplier magnitude 3, so latency 3 and a positive result.
        launch(1'b1, 1'b1, 16'hFFFE, 16'hFFFD);
        wait_done(1'b1, 25, e);
        n_checks++;
        if (e !== 3 || bus1.product !== 32'd6 || bus1.overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL ee_signed_m2xm3: edge=%0d product=%h ovf=%b, required 3 00000006 0",
                     e, bus1.product, bus1.overflow);
        end
    endtask

    task automatic test_start_ignored();
        int done_edge = -1;
        launch(1'b0, 1'b0, 16'd100, 16'd3);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            bus0.start       = (k >= 4 && k <= 10);
            bus0.signed_mode = 1'b1;
            bus0.Mem_Dat_X   = 16'hFFFF;
            bus0.Mem_Dat_Y   = 16'hFFFF;
            @(posedge clk);
            #1;
            if (bus0.done === 1'b1 && done_edge < 0) done_edge = k;
        end
        bus0.start = 1'b0;
        n_checks++;
        if (done_edge !== 17 || bus0.product !== 32'd300 || bus0.overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL start_ignored: edge=%0d product=%h ovf=%b, required 17 0000012C 0",
                     done_edge, bus0.product, bus0.overflow);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus0.busy !== 1'b0 || bus0.product !== 32'd300) begin
            n_fails++;
            $display("FAIL start_not_queued: busy=%b product=%h, required 0 0000012C",
                     bus0.busy, bus0.product);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        launch(1'b0, 1'b0, 16'd3, 16'd4);
        wait_done(1'b0, 25, e);
        n_checks++;
        if (e !== 17 || bus0.product !== 32'd12) begin
            n_fails++;
            $display("FAIL b2b_first: edge=%0d product=%h, required 17 0000000C", e, bus0.product);
        end
        // start raised while done is still high.
        launch(1'b0, 1'b0, 16'd6, 16'd7);
        n_checks++;
        if (bus0.busy !== 1'b1 || bus0.done !== 1'b0 || bus0.product !== 32'd12) begin
            n_fails++;
            $display("FAIL b2b_hold: busy=%b done=%b product=%h, required 1 0 0000000C",
                     bus0.busy, bus0.done, bus0.product);
        end
        wait_done(1'b0, 25, e);
        n_checks++;
        if (e !== 17 || bus0.product !== 32'd42) begin
            n_fails++;
            $display("FAIL b2b_second: edge=%0d product=%h, required 17 0000002A", e, bus0.product);
        end
    endtask

    task automatic test_reset_mid_run();
        int e;
        int seen = 0;
        launch(1'b0, 1'b1, 16'd10, 16'hFFF1);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus0.busy, bus0.done, bus0.overflow} !== 3'b000 || bus0.product !== 32'h0) begin
            n_fails++;
            $display("FAIL midrun_reset: busy=%b done=%b ovf=%b product=%h, required all zero",
                     bus0.busy, bus0.done, bus0.overflow, bus0.product);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus0.done === 1'b1 || bus0.busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fails++;
            $display("FAIL midrun_no_done: %0d active cycles after reset, required 0", seen);
        end
        launch(1'b0, 1'b0, 16'd9, 16'd9);
        wait_done(1'b0, 25, e);
        n_checks++;
        if (e !== 17 || bus0.product !== 32'd81 || bus0.overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL after_reset_op: edge=%0d product=%h ovf=%b, required 17 00000051 0",
                     e, bus0.product, bus0.overflow);
        end
    endtask

    initial begin
        bus0.start = 1'b0; bus0.signed_mode = 1'b0; bus0.Mem_Dat_X = '0; bus0.Mem_Dat_Y = '0;
        bus1.start = 1'b0; bus1.signed_mode = 1'b0; bus1.Mem_Dat_X = '0; bus1.Mem_Dat_Y = '0;
        test_reset();
        test_signed_basic();
        test_unsigned_max();
        test_most_negative();
        test_early_exit();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Parametrised hardware shift-and-add multiplier.
- Replaces the opcode-sequenced multiply that control currently runs step by step (load X/Y, AND with the LSB, shift, add, two's-complement fixup).
- Sits beside control and takes operands from the Mem_Dat_X / Mem_Dat_Y buses.
- One start pulse yields a full-width signed or unsigned product, with busy/done handshake and optional early termination.

Parameters:
- WIDTH, 16, operand width in bits (≥4); product is 2*WIDTH.
- EARLY_EXIT, 0, when 1 the RUN phase ends as soon as the remaining multiplier bits are all zero.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- Mem_Dat_X  in  WIDTH  multiplicand; sampled with start.
- Mem_Dat_Y  in  WIDTH  multiplier; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; product and overflow are valid.
- product  out  2*WIDTH  registered result; held until the next done.
- overflow  out  1  result not representable in WIDTH bits in the selected mode; held with product.

Behaviour:
- Reset: asynchronous, acts immediately, from any state including mid-RUN.
  - state=IDLE, busy=0, done=0, product=0, overflow=0.
  - Internal accumulator, multiplicand, multiplier, iteration counter and sign flag all cleared.
  - An interrupted operation is lost; no done is produced.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1, latch the magnitudes of X and Y. In signed mode a negative operand is negated; in unsigned mode operands are used as-is.
  - Latch neg = signed_mode & (X[MSB] ^ Y[MSB]).
  - Clear the accumulator (2*WIDTH bits) and the counter, set busy=1, go to RUN.
- RUN, one iteration per edge:
  - If multiplier LSB=1, accumulator += multiplicand (zero-extended to 2*WIDTH).
  - Then multiplicand <<= 1, multiplier >>= 1 (logical), counter += 1.
  - Leave to FIX when counter reaches WIDTH, or, with EARLY_EXIT=1, when the post-shift multiplier is zero. At least one RUN iteration always occurs.
- FIX, one edge:
  - product <= neg ? -accumulator (2*WIDTH two's complement) : accumulator.
  - overflow computed from the final product:
    - Unsigned mode: 1 if product[2W-1:W] != 0.
    - Signed mode: 1 if product[2W-1:W-1] is not all-equal bits.
  - done=1, busy=0, go to IDLE.
- done is cleared on the next edge, so the pulse is exactly one cycle.
- Latency:
  - Counted from the edge that samples start; done rises at edge RUN_iters+1.
  - EARLY_EXIT=0: always WIDTH+1 edges.
  - EARLY_EXIT=1: (index of Y-magnitude MSB set)+2 edges; Y=0 gives 2.
- start asserted while busy=1, or in the FIX cycle, is ignored; it is not queued.
- start may be asserted in the same cycle done is high. IDLE is already active on that edge, so the new operation begins and product keeps the old value until its own FIX.
- Corner case: the most-negative operand has magnitude 2^(WIDTH-1), which fits the unsigned magnitude register. (-2^(W-1))² = 2^(2W-2) fits the 2W-bit signed product.
- Operand or mode changes after the sampling edge have no effect.

Test Plan:
- WIDTH=16, EARLY_EXIT=0, signed, X=10, Y=-15, start pulse:
  - busy high for 17 cycles, then done for 1 cycle.
  - product=0xFFFFFF6A (-150), overflow=0.
- Unsigned, X=0xFFFF, Y=0xFFFF: product=0xFFFE0001, overflow=1, done at edge 17.
- Signed, X=Y=0x8000: product=0x40000000, overflow=1. Repeat with X=0x8000, Y=1: product=0xFFFF8000, overflow=0.
- EARLY_EXIT=1, unsigned:
  - X=5, Y=3: done at edge 3, product=15.
  - X=7, Y=0: done at edge 2, product=0.
- Start reasserted on edges 4–10 during an operation: ignored, result and timing unchanged. Back-to-back start in the done cycle: second result correct after WIDTH+1 more edges.
- rst pulsed asynchronously mid-RUN at edge 8: busy/done/product/overflow go to 0 immediately, no done follows; the next start completes normally.
